timer_apb_ctrl: RTL and testbench

APB-programmable controller that sequences the 8-bit timer datapath: holds reload/control/status registers, issues the load strobe and count-enable ticks, observes expiry, and raises an interrupt. Sits between the APB bus and the timer counter; the counter datapath itself stays outside this block.

---
 rtl/timer_ctrl_pkg.sv | 26 ++
 rtl/timer_prescaler.sv | 29 ++
 rtl/timer_apb_ctrl.sv | 165 ++++++++++++++++
 tb/tb_timer_apb_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared constants for the timer controller: register map, field positions
// and sequencing FSM states.
package timer_ctrl_pkg;

   localparam logic [1:0] ADDR_LOAD   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_COUNT  = 2'd3;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE    = 1;
   localparam int CTRL_IE      = 2;
   localparam int CTRL_PRE_LSB = 4;

   localparam int STAT_DONE    = 0;
   localparam int STAT_RUNNING = 1;
   localparam int STAT_OVR     = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_RUN    = 2'd2,
      ST_EXPIRE = 2'd3
   } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Count-enable divider: tick once every div+1 cycles, restarting from zero
// whenever clear is held.
module timer_prescaler #(
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [PRE_W-1:0] div,
   output logic             tick
);

   logic [PRE_W-1:0] cnt_r;

   // >= keeps the divider from running away if div shrinks mid-count
   assign tick = (cnt_r >= div);

   // Divider counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {PRE_W{1'b0}};
      end else if (clear || tick) begin
         cnt_r <= {PRE_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + {{(PRE_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/timer_apb_ctrl.sv
// APB register block and sequencing FSM for the 8-bit timer datapath.
// Optional prescaler: define TIMER_CTRL_PRESCALE_EN to implement CTRL[7:4].
module timer_apb_ctrl
   import timer_ctrl_pkg::*;
#(
   parameter int DW    = 8,
   parameter int PRE_W = 4
) (
   input  logic          PCLK,
   input  logic          PRESET,
   input  logic          PSEL,
   input  logic          PENABLE,
   input  logic          PWRITE,
   input  logic [1:0]    PADDR,
   input  logic [DW-1:0] PWDATA,
   output logic [DW-1:0] PRDATA,
   output logic          PREADY,
   output logic [DW-1:0] timer_in,
   output logic          load,
   output logic          c_enable,
   input  logic [DW-1:0] count_val,
   input  logic          trig,
   output logic          irq
);

   state_e           state_r, state_n;
   logic [DW-1:0]    load_r, prdata_r, ctrl_rd_s, stat_rd_s;
   logic             en_r, mode_r, ie_r, done_r, ovr_r, irq_r;
   logic             en_n, ie_n, done_n, ovr_n;
   logic [PRE_W-1:0] pre_rd_s;
   logic             tick_s;
   logic             wr_s, rd_s, load_wr_s, ctrl_wr_s, stat_wr_s;

   assign wr_s      = PSEL & PENABLE & PWRITE;
   assign rd_s      = PSEL & ~PENABLE & ~PWRITE;
   assign load_wr_s = wr_s & (PADDR == ADDR_LOAD);
   assign ctrl_wr_s = wr_s & (PADDR == ADDR_CTRL);
   assign stat_wr_s = wr_s & (PADDR == ADDR_STATUS);

`ifdef TIMER_CTRL_PRESCALE_EN
   logic [PRE_W-1:0] pre_r;

   // Prescale field of CTRL
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         pre_r <= {PRE_W{1'b0}};
      end else if (ctrl_wr_s) begin
         pre_r <= PWDATA[CTRL_PRE_LSB +: PRE_W];
      end else begin
         pre_r <= pre_r;
      end
   end

   assign pre_rd_s = pre_r;

   timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
      .clk   (PCLK),
      .rst   (PRESET),
      .clear (state_r != ST_RUN),
      .div   (pre_r),
      .tick  (tick_s)
   );
`else
   assign pre_rd_s = {PRE_W{1'b0}};
   assign tick_s   = 1'b1;
`endif

   // Sequencer next state; expiry outranks a same-cycle EN-clear write
   always_comb begin
      state_n = state_r;
      case (state_r)
         ST_IDLE:   if (ctrl_wr_s && PWDATA[CTRL_EN]) state_n = ST_LOAD;
                    else                              state_n = ST_IDLE;
         ST_LOAD:   if (load_r == {DW{1'b0}})         state_n = ST_EXPIRE;
                    else                              state_n = ST_RUN;
         ST_RUN:    if (trig)                         state_n = ST_EXPIRE;
                    else if (!en_r || (ctrl_wr_s && !PWDATA[CTRL_EN]))
                                                      state_n = ST_IDLE;
                    else                              state_n = ST_RUN;
         ST_EXPIRE: if (mode_r && en_r)               state_n = ST_LOAD;
                    else                              state_n = ST_IDLE;
         default:                                     state_n = ST_IDLE;
      endcase
   end

   // Next values of CTRL/STATUS flags; hardware set beats W1C clear
   always_comb begin
      en_n   = en_r;
      ie_n   = ie_r;
      done_n = done_r;
      ovr_n  = ovr_r;
      if (state_r == ST_EXPIRE && state_n == ST_IDLE) en_n = 1'b0;
      else if (ctrl_wr_s)                             en_n = PWDATA[CTRL_EN];
      else                                            en_n = en_r;
      if (ctrl_wr_s) ie_n = PWDATA[CTRL_IE];
      else           ie_n = ie_r;
      if (state_r == ST_EXPIRE)                     done_n = 1'b1;
      else if (stat_wr_s && PWDATA[STAT_DONE])      done_n = 1'b0;
      else                                          done_n = done_r;
      if (state_r == ST_EXPIRE && done_r)           ovr_n = 1'b1;
      else if (stat_wr_s && PWDATA[STAT_OVR])       ovr_n = 1'b0;
      else                                          ovr_n = ovr_r;
   end

   // Read-back images of CTRL and STATUS
   always_comb begin
      ctrl_rd_s                            = {DW{1'b0}};
      ctrl_rd_s[CTRL_EN]                   = en_r;
      ctrl_rd_s[CTRL_MODE]                 = mode_r;
      ctrl_rd_s[CTRL_IE]                   = ie_r;
      ctrl_rd_s[CTRL_PRE_LSB +: PRE_W]     = pre_rd_s;
      stat_rd_s                            = {DW{1'b0}};
      stat_rd_s[STAT_DONE]                 = done_r;
      stat_rd_s[STAT_RUNNING]              = (state_r != ST_IDLE);
      stat_rd_s[STAT_OVR]                  = ovr_r;
   end

   // State and register file
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_r <= ST_IDLE;
         load_r  <= {DW{1'b0}};
         en_r    <= 1'b0;
         mode_r  <= 1'b0;
         ie_r    <= 1'b0;
         done_r  <= 1'b0;
         ovr_r   <= 1'b0;
         irq_r   <= 1'b0;
      end else begin
         state_r <= state_n;
         load_r  <= load_wr_s ? PWDATA : load_r;
         mode_r  <= ctrl_wr_s ? PWDATA[CTRL_MODE] : mode_r;
         en_r    <= en_n;
         ie_r    <= ie_n;
         done_r  <= done_n;
         ovr_r   <= ovr_n;
         irq_r   <= ie_n & done_n;
      end
   end

   // Read data captured at the end of the setup phase, held otherwise
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         prdata_r <= {DW{1'b0}};
      end else if (rd_s) begin
         case (PADDR)
            ADDR_LOAD:   prdata_r <= load_r;
            ADDR_CTRL:   prdata_r <= ctrl_rd_s;
            ADDR_STATUS: prdata_r <= stat_rd_s;
            ADDR_COUNT:  prdata_r <= count_val;
            default:     prdata_r <= {DW{1'b0}};
         endcase
      end else begin
         prdata_r <= prdata_r;
      end
   end

   assign PRDATA   = prdata_r;
   assign PREADY   = 1'b1;
   assign timer_in = load_r;
   assign load     = (state_r == ST_LOAD);
   assign c_enable = (state_r == ST_RUN) & tick_s;
   assign irq      = irq_r;

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// Self-checking bench for timer_apb_ctrl with a behavioural down-counter
// standing in for the timer datapath; read data is scoreboarded.
module tb_timer_apb_ctrl;
   import timer_ctrl_pkg::*;

`ifdef TIMER_CTRL_PRESCALE_EN
   localparam int         PRE     = 2;
   localparam logic [7:0] CTRL_RB = 8'h23;
`else
   localparam int         PRE     = 0;
   localparam logic [7:0] CTRL_RB = 8'h03;
`endif

   logic       PCLK = 1'b0, PRESET = 1'b1;
   logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [1:0] PADDR = 2'd0;
   logic [7:0] PWDATA = 8'h00;
   logic [7:0] PRDATA, timer_in, count_val;
   logic       PREADY, load, c_enable, trig, irq;
   logic [7:0] dp_cnt;
   logic       trig_force = 1'b0, cv_ovr = 1'b0;

   int checks = 0, errors = 0;
   logic [7:0] exp_q[$];
   string      tag_q[$];
   int cyc = 0, load_cnt = 0, cen_cnt = 0, load_cyc = 0, last_cen = 0;
   bit first_pending = 1'b0;
   int lat_q[$], gap_q[$];
   int base_load, base_cen, nl, ng;

   timer_apb_ctrl dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .timer_in(timer_in), .load(load), .c_enable(c_enable),
      .count_val(count_val), .trig(trig), .irq(irq)
   );

   always #5 PCLK = ~PCLK;

   // Datapath stand-in: reload on load, decrement on c_enable
   always @(posedge PCLK or posedge PRESET) begin
      if (PRESET)        dp_cnt <= 8'd0;
      else if (load)     dp_cnt <= timer_in;
      else if (c_enable) dp_cnt <= dp_cnt - 8'd1;
      else               dp_cnt <= dp_cnt;
   end

   assign trig      = (dp_cnt == 8'd0) | trig_force;
   assign count_val = cv_ovr ? 8'h3C : dp_cnt;

   // Strobe monitor: pulse counts, first-tick latency and tick spacing
   always @(posedge PCLK) begin
      if (!PRESET) begin
         cyc <= cyc + 1;
         if (load) begin
            load_cnt      <= load_cnt + 1;
            load_cyc      <= cyc;
            first_pending <= 1'b1;
         end
         if (c_enable) begin
            cen_cnt <= cen_cnt + 1;
            if (first_pending) begin
               lat_q.push_back(cyc - load_cyc);
               first_pending <= 1'b0;
            end else begin
               gap_q.push_back(cyc - last_cen);
            end
            last_cen <= cyc;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
      end
   endtask

   // trig_ph: 0 none, 1 assert trig in setup phase, 2 in access phase
   task automatic apb_wr(input logic [1:0] addr, input logic [7:0] data, input int trig_ph);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
      trig_force = (trig_ph == 1);
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      trig_force = (trig_ph == 2);
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; trig_force = 1'b0;
   endtask

   task automatic apb_rd(input logic [1:0] addr, input logic [7:0] exp, input string tag);
      logic [7:0] got;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      got = PRDATA;
      check_val(tag_q.pop_front(), 32'(got), 32'(exp_q.pop_front()));
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge PCLK);
      check_val("rst_prdata",   32'(PRDATA),   32'h0);
      check_val("rst_pready",   32'(PREADY),   32'h1);
      check_val("rst_timer_in", 32'(timer_in), 32'h0);
      check_val("rst_load",     32'(load),     32'h0);
      check_val("rst_cen",      32'(c_enable), 32'h0);
      check_val("rst_irq",      32'(irq),      32'h0);
      PRESET = 1'b0;
      apb_rd(ADDR_STATUS, 8'h00, "rst_status");
      apb_rd(ADDR_CTRL,   8'h00, "rst_ctrl");

      // One-shot, IE, no prescale
      apb_wr(ADDR_LOAD, 8'd5, 0);
      base_load = load_cnt; base_cen = cen_cnt;
      apb_wr(ADDR_CTRL, 8'h05, 0);
      for (int i = 0; i < 50 && irq !== 1'b1; i++) @(negedge PCLK);
      check_val("os_irq",      32'(irq), 32'h1);
      check_val("os_loads",    32'(load_cnt - base_load), 32'd1);
      check_val("os_ticks",    32'(cen_cnt - base_cen),   32'd6);
      check_val("os_timer_in", 32'(timer_in), 32'h05);
      apb_rd(ADDR_STATUS, 8'h01, "os_status");
      apb_rd(ADDR_CTRL,   8'h04, "os_ctrl_en_clr");
      apb_wr(ADDR_STATUS, 8'h01, 0);
      @(negedge PCLK);
      check_val("w1c_irq", 32'(irq), 32'h0);
      apb_rd(ADDR_STATUS, 8'h00, "w1c_status");

      // Periodic with prescale, second expiry without DONE clear
      apb_wr(ADDR_LOAD, 8'd2, 0);
      base_load = load_cnt; nl = lat_q.size(); ng = gap_q.size();
      apb_wr(ADDR_CTRL, 8'h23, 0);
      for (int i = 0; i < 200 && (load_cnt - base_load) < 3; i++) @(negedge PCLK);
      check_val("per_reloads", 32'((load_cnt - base_load) >= 3), 32'h1);
      check_val("per_latency", 32'((lat_q.size() > nl) ? lat_q[nl] : -1), 32'(PRE + 1));
      check_val("per_gap",     32'((gap_q.size() > ng) ? gap_q[ng] : -1), 32'(PRE + 1));
      apb_rd(ADDR_CTRL,   CTRL_RB, "per_ctrl");
      apb_rd(ADDR_STATUS, 8'h07,   "per_ovr_status");
      apb_wr(ADDR_CTRL, 8'h00, 0);
      repeat (10) @(negedge PCLK);
      apb_rd(ADDR_STATUS, 8'h05, "per_stopped");
      apb_rd(ADDR_CTRL,   8'h00, "per_ctrl_off");
      apb_wr(ADDR_STATUS, 8'h05, 0);
      apb_rd(ADDR_STATUS, 8'h00, "per_cleared");

      // Zero reload: straight to expiry, DONE/irq two edges after write
      apb_wr(ADDR_LOAD, 8'd0, 0);
      base_load = load_cnt; base_cen = cen_cnt;
      apb_wr(ADDR_CTRL, 8'h05, 0);
      @(negedge PCLK); check_val("zero_irq_c0", 32'(irq), 32'h0);
      @(negedge PCLK); check_val("zero_irq_c1", 32'(irq), 32'h0);
      @(negedge PCLK); check_val("zero_irq_c2", 32'(irq), 32'h1);
      check_val("zero_ticks", 32'(cen_cnt - base_cen),   32'd0);
      check_val("zero_loads", 32'(load_cnt - base_load), 32'd1);
      apb_rd(ADDR_STATUS, 8'h01, "zero_status");
      apb_rd(ADDR_CTRL,   8'h04, "zero_ctrl");
      apb_wr(ADDR_STATUS, 8'h05, 0);

      // trig coincident with EN-clear write
      apb_wr(ADDR_LOAD, 8'hC8, 0);
      apb_wr(ADDR_CTRL, 8'h01, 0);
      repeat (3) @(negedge PCLK);
      apb_wr(ADDR_CTRL, 8'h00, 2);
      apb_rd(ADDR_STATUS, 8'h01, "sim_trig_status");
      apb_rd(ADDR_CTRL,   8'h00, "sim_trig_ctrl");
      base_cen = cen_cnt;
      repeat (5) @(negedge PCLK);
      check_val("sim_trig_idle", 32'(cen_cnt - base_cen), 32'd0);

      // W1C of DONE coincident with EXPIRE: set wins, OVR flags it
      apb_wr(ADDR_CTRL, 8'h01, 0);
      repeat (3) @(negedge PCLK);
      apb_wr(ADDR_STATUS, 8'h01, 1);
      repeat (2) @(negedge PCLK);
      apb_rd(ADDR_STATUS, 8'h05, "w1c_vs_set");
      apb_rd(ADDR_CTRL,   8'h00, "w1c_vs_set_ctrl");

      // Read-only RUNNING and COUNT
      apb_wr(ADDR_CTRL, 8'h01, 0);
      repeat (2) @(negedge PCLK);
      apb_wr(ADDR_STATUS, 8'h02, 0);
      apb_rd(ADDR_STATUS, 8'h07, "ro_running");
      cv_ovr = 1'b1;
      apb_rd(ADDR_COUNT, 8'h3C, "count_read");
      cv_ovr = 1'b0;
      apb_rd(ADDR_LOAD, 8'hC8, "load_read");
      check_val("timer_in_mirror", 32'(timer_in), 32'hC8);

      // Asynchronous reset while ticking
      @(negedge PCLK);
      check_val("pre_rst_cen", 32'(c_enable), 32'h1);
      #2 PRESET = 1'b1;
      #1;
      check_val("mid_rst_cen",      32'(c_enable), 32'h0);
      check_val("mid_rst_load",     32'(load),     32'h0);
      check_val("mid_rst_irq",      32'(irq),      32'h0);
      check_val("mid_rst_prdata",   32'(PRDATA),   32'h0);
      check_val("mid_rst_timer_in", 32'(timer_in), 32'h0);
      @(negedge PCLK);
      PRESET = 1'b0;
      apb_rd(ADDR_STATUS, 8'h00, "post_rst_status");
      apb_rd(ADDR_CTRL,   8'h00, "post_rst_ctrl");
      apb_rd(ADDR_LOAD,   8'h00, "post_rst_load");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
